nco_freq_meter: RTL
===================

NCO_FREQ_METER -- requirements
Module: nco_freq_meter

Interface
REQ-001 Parameter GATE_LOG2, default 20: gate window length is 2^GATE_LOG2 clk cycles; legal range 4..32.
REQ-002 Parameter CONTINUOUS, default 0: 1 = back-to-back measurements with no dead cycles; 0 = one measurement per start.
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sig_in  input  1  asynchronous 1-bit signal under measurement.
REQ-006 start  input  1  single-cycle request to begin a measurement; sampled only in IDLE.
REQ-007 busy  output  1  high while a gate window is in progress.
REQ-008 meas_valid  output  1  one-cycle pulse: new result on phase_inc_meas and edge_count.
REQ-009 edge_count  output  GATE_LOG2  rising edges counted in the last completed window.
REQ-010 phase_inc_meas  output  64  NCO phase increment equal to the measured frequency, directly loadable into the NCO phase_inc_carr input.

Function
REQ-011 sig_in SHALL pass a 2-flop synchronizer; a rising edge is synchronized sample high while the previous synchronized sample is low.
REQ-012 FSM states SHALL be IDLE and GATE only.
REQ-013 IDLE: start=1 -> GATE next cycle, gate counter and edge counter cleared to 0; start=0 -> stay IDLE.
REQ-014 GATE SHALL last exactly 2^GATE_LOG2 cycles; the edge counter increments on each cycle with a detected rising edge, including the first and last gate cycles.
REQ-015 On the last gate cycle, the final count, including any edge detected that cycle, SHALL register into edge_count and phase_inc_meas; meas_valid is high on the following cycle only.
REQ-016 phase_inc_meas SHALL equal edge_count shifted left by (64 - GATE_LOG2), zero-filled; no divider and no rounding.
REQ-017 The edge counter SHALL be GATE_LOG2 bits wide; the synchronizer limits edges per window to 2^(GATE_LOG2-1), so it never wraps.
REQ-018 After the last gate cycle: CONTINUOUS=0 -> IDLE; CONTINUOUS=1 -> GATE again with counters cleared, no gap cycles, and no edge lost or double-counted across the boundary.
REQ-019 busy SHALL be high in every GATE cycle and low in IDLE; with CONTINUOUS=1 it stays high across window boundaries.
REQ-020 start asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-021 edge_count and phase_inc_meas SHALL hold their value until the next window completes.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, busy=0, meas_valid=0, edge_count=0, phase_inc_meas=0, and clear the synchronizer and counters.
REQ-023 Reset during GATE SHALL abort the window with no meas_valid; release SHALL leave the block in IDLE, awaiting start even when CONTINUOUS=1.

Configuration
REQ-024 Macro NCO_FREQ_METER_GLITCH_FILTER_EN defined: a 3-sample majority filter follows the synchronizer; edge detection uses the filter output (2 extra cycles of latency), so single-cycle pulses are not counted.
REQ-025 Macro NCO_FREQ_METER_GLITCH_FILTER_EN undefined: no filter; edge detection uses the synchronizer output directly.

Verification
REQ-026 GATE_LOG2=8, sig_in square wave of period 8 clk, single start -> meas_valid once; edge_count=32; phase_inc_meas=0x2000_0000_0000_0000.
REQ-027 GATE_LOG2=8, sig_in toggling every clk, filter off -> edge_count=128; phase_inc_meas=0x8000_0000_0000_0000.
REQ-028 sig_in held at 1, start -> edge_count=0; phase_inc_meas=0; meas_valid pulses 257 cycles after start.
REQ-029 start pulsed mid-window, then rst_n low at gate cycle 100 -> second start has no effect; after reset busy=0, no meas_valid, outputs 0.
REQ-030 CONTINUOUS=1, period-16 wave, GATE_LOG2=8 -> meas_valid every 256 cycles; every result edge_count=16; busy never drops.
REQ-031 Isolated single-cycle high pulses on sig_in every 10 clk, GATE_LOG2=8 -> filter on: edge_count=0; filter off: edge_count=25 or 26.

Source files
------------

// File: rtl/nco_freq_meter.sv
// nco_freq_meter: gated rising-edge counter whose result is also presented as a
// 64-bit NCO phase increment (edge count scaled by 2^(64-GATE_LOG2)).
// Optional macro NCO_FREQ_METER_GLITCH_FILTER_EN inserts a 3-sample majority
// filter after the input synchronizer so single-cycle pulses are rejected.
module nco_freq_meter #(
  parameter int GATE_LOG2  = 20,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sig_in,
  input  logic                 start,
  output logic                 busy,
  output logic                 meas_valid,
  output logic [GATE_LOG2-1:0] edge_count,
  output logic [63:0]          phase_inc_meas
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic                 cur_s, edge_s, last_s;
  logic [GATE_LOG2-1:0] gate_cnt_q, gate_cnt_d;
  logic [GATE_LOG2-1:0] edge_cnt_q, edge_cnt_d;
  logic [GATE_LOG2-1:0] edge_sum_s;
  logic [GATE_LOG2-1:0] edge_count_q, edge_count_d;
  logic [63:0]          phase_q, phase_d;
  logic                 meas_valid_q, meas_valid_d;
  logic                 busy_q, busy_d;

  // Two-flop synchronizer for the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef NCO_FREQ_METER_GLITCH_FILTER_EN
  logic tap_a_q, tap_b_q, filt_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Majority of the last three synchronized samples, registered (2 cycles added).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_a_q <= 1'b0;
      tap_b_q <= 1'b0;
      filt_q  <= 1'b0;
    end else begin
      tap_a_q <= sync2_q;
      tap_b_q <= tap_a_q;
      filt_q  <= maj3(sync2_q, tap_a_q, tap_b_q);
    end
  end

  assign cur_s = filt_q;
`else
  assign cur_s = sync2_q;
`endif

  assign edge_s     = cur_s & ~prev_q;
  assign last_s     = (gate_cnt_q == {GATE_LOG2{1'b1}});
  assign edge_sum_s = edge_cnt_q + GATE_LOG2'(edge_s);

  // Next-state, counter and result logic; the final window count includes an
  // edge seen on the last gate cycle, and the next window starts from zero.
  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    edge_count_d = edge_count_q;
    phase_d      = phase_q;
    meas_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = GATE;
          gate_cnt_d = {GATE_LOG2{1'b0}};
          edge_cnt_d = {GATE_LOG2{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      GATE: begin
        if (last_s) begin
          edge_count_d = edge_sum_s;
          phase_d      = {edge_sum_s, {(64-GATE_LOG2){1'b0}}};
          meas_valid_d = 1'b1;
          gate_cnt_d   = {GATE_LOG2{1'b0}};
          edge_cnt_d   = {GATE_LOG2{1'b0}};
          state_d      = CONTINUOUS ? GATE : IDLE;
        end else begin
          gate_cnt_d = gate_cnt_q + GATE_LOG2'(1);
          edge_cnt_d = edge_sum_s;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == GATE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      prev_q       <= 1'b0;
      gate_cnt_q   <= {GATE_LOG2{1'b0}};
      edge_cnt_q   <= {GATE_LOG2{1'b0}};
      edge_count_q <= {GATE_LOG2{1'b0}};
      phase_q      <= 64'd0;
      meas_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= cur_s;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      edge_count_q <= edge_count_d;
      phase_q      <= phase_d;
      meas_valid_q <= meas_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign busy           = busy_q;
  assign meas_valid     = meas_valid_q;
  assign edge_count     = edge_count_q;
  assign phase_inc_meas = phase_q;

endmodule
